// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port 16-bit data memory (two byte lanes) between the
//   openMSP430 core and one auxiliary master (DMA engine or UART loader).
//   The core always wins because it cannot be stalled on its dmem pins. The
//   aux master only gets a slot in cycles where the core leaves memory idle.
//
// Parameters
//   AW           memory word-address width
//   DW           data width (16: two byte lanes)
//   STARVE_LIMIT aux pending cycles before aux_starve asserts (1..65535)
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_cen/wen/addr/din         core dmem request (active-low enables)
//   cpu_dout                     read data to core (held between core reads)
//   aux_req/we/addr/wdata        aux request (level, fields stable until gnt)
//   aux_gnt                      pulse: aux access issued to memory this cycle
//   aux_rdata/aux_rvalid         registered aux read data and its valid pulse
//   aux_starve                   aux pending for >= STARVE_LIMIT cycles
//   mem_cen/wen/addr/din/dout    RAM interface (sync RAM, data next cycle)
//
// Optional feature (macro DMEM_ARB_STAT_EN)
//   Adds stat_clr (in) and stat_aux_cnt (out, 16): saturating count of aux
//   grants with a synchronous clear that beats a same-cycle increment.

module dmem_arbiter #(
  parameter int AW           = 7,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic [1:0]    cpu_wen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic          aux_req,
  input  logic [1:0]    aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_gnt,
  output logic [DW-1:0] aux_rdata,
  output logic          aux_rvalid,
  output logic          aux_starve,
  output logic          mem_cen,
  output logic [1:0]    mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
`ifdef DMEM_ARB_STAT_EN
  ,
  input  logic          stat_clr,
  output logic [15:0]   stat_aux_cnt
`endif
);

  localparam logic [15:0] STARVE_LIM = 16'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_DATA = 1'b1
  } state_t;

  state_t        state_r;
  logic          aux_gnt_s;
  logic          cpu_rd_r;
  logic [DW-1:0] cpu_hold_r;
  logic [15:0]   starve_cnt_r;
  logic [15:0]   starve_cnt_nxt_s;

  // Grant aux only in core-idle cycles and never while an aux read is in flight.
  always_comb begin
    aux_gnt_s = 1'b0;
    if (aux_req && cpu_cen && (state_r == ST_IDLE)) begin
      aux_gnt_s = 1'b1;
    end else begin
      aux_gnt_s = 1'b0;
    end
  end

  assign aux_gnt = aux_gnt_s;

  // Memory mux: core first, then a granted aux access, else memory idle.
  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 2'b11;
    mem_addr = cpu_addr;
    mem_din  = cpu_din;
    if (!cpu_cen) begin
      mem_cen  = 1'b0;
      mem_wen  = cpu_wen;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end else if (aux_gnt_s) begin
      mem_cen  = 1'b0;
      mem_wen  = ~aux_we;
      mem_addr = aux_addr;
      mem_din  = aux_wdata;
    end else begin
      mem_cen  = 1'b1;
      mem_wen  = 2'b11;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end
  end

  // Aux read FSM: a granted read returns its data two cycles after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      aux_rdata  <= {DW{1'b0}};
      aux_rvalid <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          aux_rvalid <= 1'b0;
          // A write completes at the grant itself, so only reads leave IDLE.
          if (aux_gnt_s && (aux_we == 2'b00)) begin
            state_r <= ST_RD_DATA;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_DATA: begin
          aux_rdata  <= mem_dout;
          aux_rvalid <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          aux_rvalid <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Track core reads and hold their data so aux reads never disturb cpu_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rd_r   <= 1'b0;
      cpu_hold_r <= {DW{1'b0}};
    end else begin
      cpu_rd_r <= ~cpu_cen & (&cpu_wen);
      if (cpu_rd_r) begin
        cpu_hold_r <= mem_dout;
      end else begin
        cpu_hold_r <= cpu_hold_r;
      end
    end
  end

  assign cpu_dout = cpu_rd_r ? mem_dout : cpu_hold_r;

  // Next starvation count: clears on grant or withdrawn request, saturates.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!aux_req || aux_gnt_s) begin
      starve_cnt_nxt_s = 16'h0000;
    end else if (starve_cnt_r == 16'hFFFF) begin
      starve_cnt_nxt_s = starve_cnt_r;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r + 16'h0001;
    end
  end

  // Starvation flag compares the next count so it rises in the pending
  // cycle that crosses the limit and drops the cycle after a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= 16'h0000;
      aux_starve   <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      aux_starve   <= (starve_cnt_nxt_s >= STARVE_LIM);
    end
  end

`ifdef DMEM_ARB_STAT_EN
  // Saturating aux grant counter; clear wins over a same-cycle grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_aux_cnt <= 16'h0000;
    end else if (stat_clr) begin
      stat_aux_cnt <= 16'h0000;
    end else if (aux_gnt_s && (stat_aux_cnt != 16'hFFFF)) begin
      stat_aux_cnt <= stat_aux_cnt + 16'h0001;
    end else begin
      stat_aux_cnt <= stat_aux_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A behavioural sync RAM sits on the
//   mem_* pins. Stimulus pushes expected aux grants and aux read returns into
//   queues; a monitor on the falling edge pops and compares them whenever the
//   DUT shows aux_gnt or aux_rvalid. Other values are checked directly.

module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_cen;
  logic [1:0]  cpu_wen;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        aux_req;
  logic [1:0]  aux_we;
  logic [6:0]  aux_addr;
  logic [15:0] aux_wdata;
  logic        aux_gnt;
  logic [15:0] aux_rdata;
  logic        aux_rvalid;
  logic        aux_starve;
  logic        mem_cen;
  logic [1:0]  mem_wen;
  logic [6:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
`ifdef DMEM_ARB_STAT_EN
  logic        stat_clr;
  logic [15:0] stat_aux_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  wen;
    logic [6:0]  addr;
    logic [15:0] din;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rd_t;

  gnt_t gnt_q[$];
  rd_t  rd_q[$];

  logic [15:0] ram [0:127];

  dmem_arbiter #(.AW(7), .DW(16), .STARVE_LIMIT(64)) dut (
    .clk(clk), .rst(rst),
    .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata),
    .aux_rvalid(aux_rvalid), .aux_starve(aux_starve),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef DMEM_ARB_STAT_EN
    , .stat_clr(stat_clr), .stat_aux_cnt(stat_aux_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to check grant and read-return latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Sync RAM with active-low byte-lane writes; data is valid the next cycle.
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen[0]) ram[mem_addr][7:0]  <= mem_din[7:0];
      if (!mem_wen[1]) ram[mem_addr][15:8] <= mem_din[15:8];
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pop an expectation for every grant / read return.
  always @(negedge clk) begin
    if (aux_gnt) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 32'(aux_gnt), 32'd0);
      end else begin
        gnt_t g;
        g = gnt_q.pop_front();
        check("gnt_cycle", 32'(cyc), 32'(g.cyc));
        check("gnt_mem_cen", 32'(mem_cen), 32'd0);
        check("gnt_mem_wen", 32'(mem_wen), 32'(g.wen));
        check("gnt_mem_addr", 32'(mem_addr), 32'(g.addr));
        check("gnt_mem_din", 32'(mem_din), 32'(g.din));
      end
    end
    if (aux_rvalid) begin
      if (rd_q.size() == 0) begin
        check("rvalid_unexpected", 32'(aux_rvalid), 32'd0);
      end else begin
        rd_t r;
        r = rd_q.pop_front();
        check("rvalid_cycle", 32'(cyc), 32'(r.cyc));
        check("aux_rdata", 32'(aux_rdata), 32'(r.data));
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_core;
    cpu_cen = 1'b1;
    cpu_wen = 2'b11;
  endtask

  task automatic core_write(input logic [6:0] a, input logic [15:0] d);
    cpu_cen  = 1'b0;
    cpu_wen  = 2'b00;
    cpu_addr = a;
    cpu_din  = d;
    nxt;
    idle_core;
  endtask

  task automatic core_read(input logic [6:0] a);
    cpu_cen  = 1'b0;
    cpu_wen  = 2'b11;
    cpu_addr = a;
    nxt;
    idle_core;
  endtask

  initial begin
    rst = 1'b1;
    cpu_cen = 1'b1; cpu_wen = 2'b11; cpu_addr = 7'd0; cpu_din = 16'h0000;
    aux_req = 1'b0; aux_we = 2'b00; aux_addr = 7'd0; aux_wdata = 16'h0000;
`ifdef DMEM_ARB_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_aux_gnt", 32'(aux_gnt), 32'd0);
    check("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
    check("rst_aux_rdata", 32'(aux_rdata), 32'd0);
    check("rst_aux_starve", 32'(aux_starve), 32'd0);
    check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("rst_mem_cen", 32'(mem_cen), 32'd1);
`ifdef DMEM_ARB_STAT_EN
    check("rst_stat_cnt", 32'(stat_aux_cnt), 32'd0);
`endif
    nxt;
    rst = 1'b0;

    // Preload RAM through the core write path.
    core_write(7'd5, 16'hBEEF);
    core_write(7'd9, 16'h1357);
    core_write(7'd2, 16'h1234);
    core_write(7'd3, 16'h5555);
    core_write(7'd7, 16'h00CD);

    // Aux read of address 5 with the core idle.
    aux_req = 1'b1; aux_we = 2'b00; aux_addr = 7'd5; aux_wdata = 16'h0000;
    gnt_q.push_back('{cyc, 2'b11, 7'd5, 16'h0000});
    rd_q.push_back('{cyc + 2, 16'hBEEF});
    nxt;
    aux_req = 1'b0;
    repeat (3) nxt;

    // Core busy for 70 cycles while aux waits: starvation from pending cycle 65.
    aux_req = 1'b1; aux_we = 2'b00; aux_addr = 7'd9;
    for (int k = 1; k <= 70; k++) begin
      cpu_cen = 1'b0; cpu_wen = 2'b11; cpu_addr = 7'(k);
      @(negedge clk);
      check("starve_pending", 32'(aux_starve), (k >= 65) ? 32'd1 : 32'd0);
      if (k == 1) begin
        check("core_wins_cen", 32'(mem_cen), 32'd0);
        check("core_wins_addr", 32'(mem_addr), 32'd1);
      end
      nxt;
    end
    idle_core;
    gnt_q.push_back('{cyc, 2'b11, 7'd9, 16'h0000});
    rd_q.push_back('{cyc + 2, 16'h1357});
    @(negedge clk);
    check("starve_at_gnt", 32'(aux_starve), 32'd1);
    nxt;
    aux_req = 1'b0;
    @(negedge clk);
    check("starve_after_gnt", 32'(aux_starve), 32'd0);
    nxt;
    nxt;

    // Core reads 0x1234, then an aux read must not disturb cpu_dout.
    core_read(7'd2);
    aux_req = 1'b1; aux_we = 2'b00; aux_addr = 7'd3;
    gnt_q.push_back('{cyc, 2'b11, 7'd3, 16'h0000});
    rd_q.push_back('{cyc + 2, 16'h5555});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cpu_dout_hold", 32'(cpu_dout), 32'h1234);
      nxt;
      aux_req = 1'b0;
    end

    // Aux upper-byte write merges with the existing low byte.
    aux_req = 1'b1; aux_we = 2'b10; aux_addr = 7'd7; aux_wdata = 16'hAB00;
    gnt_q.push_back('{cyc, 2'b01, 7'd7, 16'hAB00});
    nxt;
    aux_req = 1'b0; aux_we = 2'b00; aux_wdata = 16'h0000;
    nxt;
    core_read(7'd7);
    @(negedge clk);
    check("merged_word", 32'(cpu_dout), 32'hABCD);
    nxt;
    cpu_cen = 1'b0; cpu_wen = 2'b00; cpu_addr = 7'd10; cpu_din = 16'h1111;
    @(negedge clk);
    check("core_wr_wen", 32'(mem_wen), 32'd0);
    check("core_wr_din", 32'(mem_din), 32'h1111);
    nxt;
    idle_core;
    @(negedge clk);
    check("hold_after_core_wr", 32'(cpu_dout), 32'hABCD);
    nxt;

    // A withdrawn request restarts the starvation count.
    aux_we = 2'b01; aux_addr = 7'd20; aux_wdata = 16'h0077;
    for (int k = 1; k <= 71; k++) begin
      cpu_cen = 1'b0; cpu_wen = 2'b11; cpu_addr = 7'd0;
      aux_req = (k != 61);
      @(negedge clk);
      check("starve_after_drop", 32'(aux_starve), 32'd0);
      nxt;
    end
    idle_core;
    aux_req = 1'b1;
    gnt_q.push_back('{cyc, 2'b10, 7'd20, 16'h0077});
    nxt;
    aux_req = 1'b0; aux_we = 2'b00; aux_wdata = 16'h0000;
    nxt;

    // Reset during RD_DATA aborts the read.
    aux_req = 1'b1; aux_we = 2'b00; aux_addr = 7'd5;
    gnt_q.push_back('{cyc, 2'b11, 7'd5, 16'h0000});
    nxt;
    aux_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rvalid", 32'(aux_rvalid), 32'd0);
    check("midrst_rdata", 32'(aux_rdata), 32'd0);
    check("midrst_cpu_dout", 32'(cpu_dout), 32'd0);
    check("midrst_starve", 32'(aux_starve), 32'd0);
    nxt;
    nxt;
    rst = 1'b0;
    nxt;
    aux_req = 1'b1; aux_we = 2'b00; aux_addr = 7'd3;
    gnt_q.push_back('{cyc, 2'b11, 7'd3, 16'h0000});
    rd_q.push_back('{cyc + 2, 16'h5555});
    nxt;
    aux_req = 1'b0;
    repeat (3) nxt;

`ifdef DMEM_ARB_STAT_EN
    // Grant statistics: three grants counted, clear beats a fourth grant.
    stat_clr = 1'b1;
    nxt;
    stat_clr = 1'b0;
    aux_we = 2'b11; aux_addr = 7'd30; aux_wdata = 16'h0F0F;
    for (int k = 0; k < 3; k++) begin
      aux_req = 1'b1;
      gnt_q.push_back('{cyc, 2'b00, 7'd30, 16'h0F0F});
      nxt;
    end
    aux_req = 1'b0;
    @(negedge clk);
    check("stat_three", 32'(stat_aux_cnt), 32'd3);
    nxt;
    aux_req = 1'b1; stat_clr = 1'b1;
    gnt_q.push_back('{cyc, 2'b00, 7'd30, 16'h0F0F});
    nxt;
    aux_req = 1'b0; stat_clr = 1'b0; aux_we = 2'b00;
    @(negedge clk);
    check("stat_clr_wins", 32'(stat_aux_cnt), 32'd0);
    nxt;
`endif

    repeat (4) nxt;
    check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between the openMSP430 core and one auxiliary master (DMA engine or UART loader).
- The core has absolute priority, because the core cannot be stalled on the dmem interface.
- The aux master gets a memory slot only in cycles where the core is not accessing memory (dmem_cen high).
- Sits between core dmem_* pins and the two byte-lane RAM halves; provides a req/gnt handshake, registered aux read data, a held core read-data view and a starvation flag.

Parameters:
AW, 7, memory word-address width
DW, 16, data width (must be 16; two byte lanes)
STARVE_LIMIT, 64, aux pending cycles before aux_starve asserts (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_cen  in  1  core chip enable, active-low
cpu_wen  in  2  core byte write enables, active-low
cpu_addr  in  AW  core word address
cpu_din  in  DW  core write data
cpu_dout  out  DW  read data to core
aux_req  in  1  aux request, level; held with fields stable until aux_gnt
aux_we  in  2  aux byte write enables, active-high (00 = read)
aux_addr  in  AW  aux word address
aux_wdata  in  DW  aux write data
aux_gnt  out  1  one-cycle pulse: aux access issued to memory this cycle
aux_rdata  out  DW  registered aux read data
aux_rvalid  out  1  one-cycle pulse: aux_rdata valid
aux_starve  out  1  aux pending >= STARVE_LIMIT cycles
mem_cen  out  1  RAM chip enable, active-low
mem_wen  out  2  RAM byte write enables, active-low
mem_addr  out  AW  RAM address
mem_din  out  DW  RAM write data
mem_dout  in  DW  RAM read data (sync RAM, valid the cycle after access)

Behaviour:
Reset values:
- state=IDLE; aux_gnt=0, aux_rvalid=0, aux_rdata=0, aux_starve=0.
- cpu_dout hold register=0; starve counter=0.

Memory mux (combinational):
- cpu_cen=0 -> memory driven by core signals.
- else if aux granted this cycle -> memory driven by aux: mem_cen=0, mem_wen=~aux_we.
- else mem_cen=1, mem_wen=11, addr/din hold core values.

Grant rule:
- aux_gnt = aux_req & cpu_cen & (state==IDLE). Combinational, same cycle.
- Aux master may drop or change req/fields in the cycle after gnt.

FSM:
- IDLE: on grant with aux_we==00 -> RD_DATA. On grant with a write -> stay IDLE (write complete at gnt).
- RD_DATA (one cycle): aux_rdata<=mem_dout, aux_rvalid=1 the following cycle (gnt+2); -> IDLE. No aux grant is issued in RD_DATA, so back-to-back aux reads are spaced at least 2 cycles apart.
- Core accesses are always permitted in RD_DATA.

Core read view:
- Register cpu_rd_q <= ~cpu_cen & (&cpu_wen).
- When cpu_rd_q=1: cpu_dout = mem_dout, also captured into the hold register.
- Otherwise cpu_dout = hold register, so aux reads never disturb data the core sees.
- Core writes and aux writes do not update the hold register.

Starvation:
- Counter increments each cycle aux_req=1 & !aux_gnt; saturates at 65535; clears on aux_gnt or when aux_req=0.
- aux_starve = (counter >= STARVE_LIMIT), registered.

Simultaneous events:
- Core and aux both requesting -> core wins, aux waits, no gnt.
- aux_req dropped before gnt -> request withdrawn, counter cleared.

Reset mid-operation:
- Async rst in RD_DATA aborts the read: no aux_rvalid after reset, FSM returns to IDLE.

Optional Feature:
DMEM_ARB_STAT_EN
- Defined: adds ports stat_clr (in, 1) and stat_aux_cnt (out, 16).
  - stat_aux_cnt counts aux grants, saturating at 0xFFFF.
  - Synchronous clear by stat_clr; clear takes priority over an increment in the same cycle.
  - Reset value 0.
- Undefined: ports and counter absent; all other behaviour identical.

Test Plan:
- Core idle, aux read addr 0x05 (RAM[5]=0xBEEF) -> aux_gnt at cycle T, aux_rvalid=1 and aux_rdata=0xBEEF at T+2.
- Core accessing every cycle for 70 cycles with aux_req=1, STARVE_LIMIT=64 -> no aux_gnt; aux_starve=1 from the 65th pending cycle. Core then idles -> gnt, aux_starve=0 the next cycle.
- Core reads 0x1234 from addr 2, then idles while aux reads 0x5555 from addr 3 -> cpu_dout stays 0x1234 throughout.
- Aux write aux_we=10 data 0xAB00 to addr 7 holding 0x00CD -> mem_wen=01 at gnt; a later core read returns 0xABCD.
- Assert rst during RD_DATA -> all outputs 0, no aux_rvalid; after release, a new aux request is granted normally.
- With DMEM_ARB_STAT_EN: 3 aux grants -> stat_aux_cnt=3; stat_clr coincident with a 4th grant -> 0.
